flash_user_test: RTL and testbench

- Upstream traffic master for the flash controller's user interface.
- On a start pulse it runs one self-check sequence at a fixed sector:
  - sector erase;
  - page program of P_NUM bytes with an incrementing pattern;
  - read-back of P_NUM bytes, compared byte-by-byte.
- Reports done, pass, error count and timeout.
- Used for board bring-up and regression of the flash path.

---
 rtl/flash_user_pkg.sv | 23 ++
 rtl/flash_pattern_gen.sv | 15 +
 rtl/flash_user_test.sv | 181 ++++++++++++++++++
 tb/tb_flash_user_test.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_user_pkg.sv
// Shared constants for the flash user-interface self-test master:
// controller op codes, sequencer state encoding and the default byte width.
package flash_user_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] OP_ERASE   = 2'd0;
    localparam logic [1:0] OP_PROGRAM = 2'd1;
    localparam logic [1:0] OP_READ    = 2'd2;

    typedef logic [3:0] state_t;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ERASE_REQ  = 4'd1;
    localparam logic [3:0] S_ERASE_WAIT = 4'd2;
    localparam logic [3:0] S_PROG_REQ   = 4'd3;
    localparam logic [3:0] S_PROG_DATA  = 4'd4;
    localparam logic [3:0] S_PROG_WAIT  = 4'd5;
    localparam logic [3:0] S_READ_REQ   = 4'd6;
    localparam logic [3:0] S_READ_DATA  = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

endpackage

// File: rtl/flash_pattern_gen.sv
// Expected test-pattern byte for a given stream index: seed + index, wrapping
// at the data width.
module flash_pattern_gen
    import flash_user_pkg::*;
#(
    parameter int P_DATA_WIDTH = BYTE_W
) (
    input  logic [P_DATA_WIDTH-1:0] i_seed,
    input  logic [8:0]              i_idx,
    output logic [P_DATA_WIDTH-1:0] o_byte
);

    assign o_byte = i_seed + P_DATA_WIDTH'(i_idx);

endmodule

// File: rtl/flash_user_test.sv
// Self-test traffic master for the flash controller user interface: erases one
// sector, programs an incrementing pattern, reads it back and counts errors.
module flash_user_test
    import flash_user_pkg::*;
#(
    parameter int                    P_DATA_WIDTH = BYTE_W,
    parameter logic [23:0]           P_ADDR       = 24'h000000,
    parameter int                    P_NUM        = 256,
    parameter logic [P_DATA_WIDTH-1:0] P_SEED     = 8'h00,
    parameter logic [31:0]           P_TIMEOUT    = 32'd50_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_pass,
    output logic                    o_timeout,
    output logic [8:0]              o_err_cnt,
    output logic [1:0]              o_operation_type,
    output logic [23:0]             o_operation_addr,
    output logic [8:0]              o_operation_num,
    output logic                    o_operation_valid,
    input  logic                    i_operation_ready,
    output logic [P_DATA_WIDTH-1:0] o_write_data,
    output logic                    o_write_sop,
    output logic                    o_write_eop,
    output logic                    o_write_valid,
    input  logic [P_DATA_WIDTH-1:0] i_read_data,
    input  logic                    i_read_sop,
    input  logic                    i_read_eop,
    input  logic                    i_read_valid
);

    localparam logic [8:0]  L_NUM      = 9'(P_NUM);
    localparam logic [8:0]  L_LAST     = 9'(P_NUM - 1);
    localparam logic [31:0] L_TMO_LAST = P_TIMEOUT - 32'd1;
    localparam logic [9:0]  L_ERR_MAX  = 10'd256;

    state_t                  r_state, w_state_next;
    logic [31:0]             r_tmo_cnt;
    logic [8:0]              r_wr_idx, r_rx_idx, r_err_cnt;
    logic                    r_busy, r_pass, r_timeout, r_op_valid;
    logic [1:0]              r_op_type;
    logic [23:0]             r_op_addr;
    logic [8:0]              r_op_num;
    logic                    w_fire, w_tmo_hit, w_abort, w_timed, w_rx_beat, w_wr_active;
    logic [P_DATA_WIDTH-1:0] w_wr_byte, w_rx_byte;
    logic [9:0]              w_err_inc, w_err_sum;
    logic [8:0]              w_err_next;

    flash_pattern_gen #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_wr_pattern (
        .i_seed (P_SEED),
        .i_idx  (r_wr_idx),
        .o_byte (w_wr_byte)
    );

    flash_pattern_gen #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_rx_pattern (
        .i_seed (P_SEED),
        .i_idx  (r_rx_idx),
        .o_byte (w_rx_byte)
    );

    assign w_fire      = r_op_valid && i_operation_ready;
    assign w_tmo_hit   = (r_tmo_cnt == L_TMO_LAST);
    assign w_timed     = (r_state != S_IDLE) && (r_state != S_PROG_DATA) && (r_state != S_DONE);
    assign w_rx_beat   = (r_state == S_READ_DATA) && i_read_valid;
    assign w_wr_active = (r_state == S_PROG_DATA);

    // The wait states skip the cycle right after fire (tmo count still 0),
    // when the controller has not yet dropped ready.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE:       if (i_start) w_state_next = S_ERASE_REQ;
            S_ERASE_REQ:  if (w_fire) w_state_next = S_ERASE_WAIT; else w_abort = w_tmo_hit;
            S_ERASE_WAIT: if (i_operation_ready && r_tmo_cnt != 32'd0) w_state_next = S_PROG_REQ;
                          else w_abort = w_tmo_hit;
            S_PROG_REQ:   if (w_fire) w_state_next = S_PROG_DATA; else w_abort = w_tmo_hit;
            S_PROG_DATA:  if (r_wr_idx == L_LAST) w_state_next = S_PROG_WAIT;
            S_PROG_WAIT:  if (i_operation_ready && r_tmo_cnt != 32'd0) w_state_next = S_READ_REQ;
                          else w_abort = w_tmo_hit;
            S_READ_REQ:   if (w_fire) w_state_next = S_READ_DATA; else w_abort = w_tmo_hit;
            S_READ_DATA:  if (w_rx_beat && i_read_eop) w_state_next = S_DONE; else w_abort = w_tmo_hit;
            default:      w_state_next = S_IDLE;
        endcase
        if (w_abort) w_state_next = S_DONE;
    end

    // Errors per read beat: data mismatch (or overrun), misplaced sop, and
    // the bytes an early eop leaves missing.
    always_comb begin
        w_err_inc = 10'd0;
        if (w_rx_beat) begin
            if (r_rx_idx >= L_NUM) begin
                w_err_inc = 10'd1;
            end else begin
                if (i_read_data != w_rx_byte) w_err_inc = 10'd1;
                if (i_read_eop && r_rx_idx < L_LAST) w_err_inc = w_err_inc + {1'b0, L_LAST - r_rx_idx};
            end
            if (i_read_sop != (r_rx_idx == 9'd0)) w_err_inc = w_err_inc + 10'd1;
        end
        w_err_sum  = {1'b0, r_err_cnt} + w_err_inc;
        w_err_next = (w_err_sum > L_ERR_MAX) ? 9'd256 : w_err_sum[8:0];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
            r_wr_idx  <= '0;
            r_rx_idx  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) r_tmo_cnt <= '0;
            else if (w_timed)            r_tmo_cnt <= r_tmo_cnt + 32'd1;
            r_wr_idx <= w_wr_active ? r_wr_idx + 9'd1 : 9'd0;
            if (r_state != S_READ_DATA)                r_rx_idx <= '0;
            else if (w_rx_beat && r_rx_idx != 9'h1FF)  r_rx_idx <= r_rx_idx + 9'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_op_valid <= 1'b0;
            r_op_type  <= '0;
            r_op_addr  <= '0;
            r_op_num   <= '0;
        end else begin
            r_op_valid <= (w_state_next == S_ERASE_REQ) || (w_state_next == S_PROG_REQ) ||
                          (w_state_next == S_READ_REQ);
            if (w_state_next != r_state) begin
                case (w_state_next)
                    S_ERASE_REQ: begin r_op_type <= OP_ERASE;   r_op_addr <= P_ADDR; r_op_num <= 9'd0;  end
                    S_PROG_REQ:  begin r_op_type <= OP_PROGRAM; r_op_addr <= P_ADDR; r_op_num <= L_NUM; end
                    S_READ_REQ:  begin r_op_type <= OP_READ;    r_op_addr <= P_ADDR; r_op_num <= L_NUM; end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_busy    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_err_cnt <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_busy    <= 1'b1;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_rx_beat) r_err_cnt <= w_err_next;
            if (w_abort)   r_timeout <= 1'b1;
            if (w_state_next == S_DONE && r_state != S_DONE) begin
                r_busy <= 1'b0;
                r_pass <= !w_abort && (w_err_next == 9'd0);
            end
        end
    end

    assign o_busy            = r_busy;
    assign o_done            = (r_state == S_DONE);
    assign o_pass            = r_pass;
    assign o_timeout         = r_timeout;
    assign o_err_cnt         = r_err_cnt;
    assign o_operation_type  = r_op_type;
    assign o_operation_addr  = r_op_addr;
    assign o_operation_num   = r_op_num;
    assign o_operation_valid = r_op_valid;
    assign o_write_valid     = w_wr_active;
    assign o_write_data      = w_wr_active ? w_wr_byte : '0;
    assign o_write_sop       = w_wr_active && (r_wr_idx == 9'd0);
    assign o_write_eop       = w_wr_active && (r_wr_idx == L_LAST);

endmodule

// File: tb/tb_flash_user_test.sv
// Bench for flash_user_test: a 256-byte instance driven by a behavioural flash
// controller model, plus a 1-byte instance with a non-zero seed.
module tb_flash_user_test;
    import flash_user_pkg::*;

    localparam int NUM_A = 256;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       start_a, ready_a, rvalid_a, rsop_a, reop_a;
    logic [7:0] rdata_a;
    logic       a_busy, a_done, a_pass, a_tmo, a_valid, a_wsop, a_weop, a_wvalid;
    logic [8:0] a_err, a_num;
    logic [1:0] a_type;
    logic [23:0] a_addr;
    logic [7:0] a_wdata;

    logic       start_b, ready_b, rvalid_b, rsop_b, reop_b;
    logic [7:0] rdata_b;
    logic       b_busy, b_done, b_pass, b_tmo, b_valid, b_wsop, b_weop, b_wvalid;
    logic [8:0] b_err, b_num;
    logic [1:0] b_type;
    logic [23:0] b_addr;
    logic [7:0] b_wdata;

    flash_user_test #(.P_NUM(NUM_A), .P_SEED(8'h00), .P_TIMEOUT(32'd1000)) u_dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_start(start_a),
        .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass), .o_timeout(a_tmo), .o_err_cnt(a_err),
        .o_operation_type(a_type), .o_operation_addr(a_addr), .o_operation_num(a_num),
        .o_operation_valid(a_valid), .i_operation_ready(ready_a),
        .o_write_data(a_wdata), .o_write_sop(a_wsop), .o_write_eop(a_weop), .o_write_valid(a_wvalid),
        .i_read_data(rdata_a), .i_read_sop(rsop_a), .i_read_eop(reop_a), .i_read_valid(rvalid_a)
    );

    flash_user_test #(.P_NUM(1), .P_SEED(8'hA5), .P_TIMEOUT(32'd1000)) u_dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_start(start_b),
        .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass), .o_timeout(b_tmo), .o_err_cnt(b_err),
        .o_operation_type(b_type), .o_operation_addr(b_addr), .o_operation_num(b_num),
        .o_operation_valid(b_valid), .i_operation_ready(ready_b),
        .o_write_data(b_wdata), .o_write_sop(b_wsop), .o_write_eop(b_weop), .o_write_valid(b_wvalid),
        .i_read_data(rdata_b), .i_read_sop(rsop_b), .i_read_eop(reop_b), .i_read_valid(rvalid_b)
    );

    typedef struct packed { logic [7:0] data; logic sop; logic eop; } beat_t;
    typedef struct { string name; int eop_at; bit drop_sop; int c0; int c1; int exp_err; bit exp_pass; } vec_t;

    beat_t wq[$];
    bit    corrupt [NUM_A];
    int    n_checks = 0;
    int    n_fail   = 0;

    always @(negedge clk) if (a_wvalid) wq.push_back({a_wdata, a_wsop, a_weop});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Spec-level error count: corrupted delivered bytes, missing bytes, missing sop; saturates at 256.
    function automatic int model_err(input int eop_at, input bit drop_sop);
        int e = 0;
        for (int k = 0; k <= eop_at; k++) if (corrupt[k]) e++;
        e += (NUM_A - 1 - eop_at) + (drop_sop ? 1 : 0);
        return (e > 256) ? 256 : e;
    endfunction

    // Controller side of one op: wait for the request, accept it, then stay busy.
    task automatic serve_a(input int busy, input bit keep_low, output logic [36:0] rec);
        int n = 0;
        bit ok, dropped;
        logic [1:0] t;
        logic [23:0] ad;
        logic [8:0] nm;
        while (!a_valid && n < 100) begin @(negedge clk); n++; end
        ok = a_valid; t = a_type; ad = a_addr; nm = a_num;
        @(negedge clk);
        dropped = !a_valid;
        ready_a = 1'b0;
        if (!keep_low) begin
            repeat (busy) @(negedge clk);
            ready_a = 1'b1;
        end
        rec = {ok, dropped, t, ad, nm};
    endtask

    task automatic check_write_stream(input string name);
        int bad = 0;
        beat_t e;
        if (wq.size() != NUM_A) bad++;
        else foreach (wq[k]) begin
            e.data = 8'(k); e.sop = (k == 0); e.eop = (k == NUM_A - 1);
            if (wq[k] != e) bad++;
        end
        check({name, ":write_stream"}, 64'(bad), 64'd0);
    endtask

    task automatic run_a(input string name, input int eop_at, input bit drop_sop,
                         input int exp_err, input bit exp_pass);
        logic [36:0] rec;
        wq.delete();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check({name, ":start"}, {a_valid, a_busy, a_pass, a_tmo, a_err}, {1'b1, 1'b1, 1'b0, 1'b0, 9'd0});
        serve_a($urandom_range(1, 20), 1'b0, rec);
        check({name, ":erase_op"}, 64'(rec), {1'b1, 1'b1, OP_ERASE, 24'h000000, 9'd0});
        serve_a(NUM_A + $urandom_range(2, 20), 1'b0, rec);
        check({name, ":prog_op"}, 64'(rec), {1'b1, 1'b1, OP_PROGRAM, 24'h000000, 9'd256});
        check_write_stream(name);
        serve_a(0, 1'b1, rec);
        check({name, ":read_op"}, 64'(rec), {1'b1, 1'b1, OP_READ, 24'h000000, 9'd256});
        for (int k = 0; k <= eop_at; k++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            rvalid_a = 1'b1;
            rdata_a  = wq[k].data ^ (corrupt[k] ? 8'hFF : 8'h00);
            rsop_a   = (k == 0) && !drop_sop;
            reop_a   = (k == eop_at);
            @(negedge clk);
            if (k != eop_at) begin rvalid_a = 1'b0; rsop_a = 1'b0; reop_a = 1'b0; end
        end
        check({name, ":done"}, {a_done, a_busy, a_pass, a_tmo, a_err}, {1'b1, 1'b0, exp_pass, 1'b0, 9'(exp_err)});
        rvalid_a = 1'b0; rsop_a = 1'b0; reop_a = 1'b0; ready_a = 1'b1;
        @(negedge clk);
        check({name, ":held"}, {a_done, a_busy, a_pass, a_err}, {1'b0, 1'b0, exp_pass, 9'(exp_err)});
    endtask

    task automatic wait_b_valid(output bit ok);
        int n = 0;
        while (!b_valid && n < 100) begin @(negedge clk); n++; end
        ok = b_valid;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [36:0] rec;
        bit ok, saw_op;
        int n, eop, e;
        bit ds;

        vecs[0] = '{"ideal",      255, 1'b0,  -1,  -1,   0, 1'b1};
        vecs[1] = '{"corrupt2",   255, 1'b0,  17, 200,   2, 1'b0};
        vecs[2] = '{"early_eop",   99, 1'b0,  -1,  -1, 156, 1'b0};
        vecs[3] = '{"no_sop",     255, 1'b1,  -1,  -1,   1, 1'b0};
        vecs[4] = '{"last_bad",   255, 1'b0, 255,  -1,   1, 1'b0};
        vecs[5] = '{"eop_first",    0, 1'b0,  -1,  -1, 255, 1'b0};
        vecs[6] = '{"saturate",     0, 1'b1,   0,  -1, 256, 1'b0};

        start_a = 0; ready_a = 1; rvalid_a = 0; rsop_a = 0; reop_a = 0; rdata_a = 0;
        start_b = 0; ready_b = 1; rvalid_b = 0; rsop_b = 0; reop_b = 0; rdata_b = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_a", {a_busy, a_done, a_pass, a_tmo, a_err, a_valid, a_type, a_addr, a_num,
                          a_wvalid, a_wdata, a_wsop, a_weop}, 64'd0);
        check("reset_b", {b_busy, b_done, b_pass, b_tmo, b_err, b_valid, b_type, b_addr, b_num,
                          b_wvalid, b_wdata, b_wsop, b_weop}, 64'd0);
        rst_n = 1;
        @(negedge clk);

        foreach (vecs[i]) begin
            foreach (corrupt[k]) corrupt[k] = 1'b0;
            if (vecs[i].c0 >= 0) corrupt[vecs[i].c0] = 1'b1;
            if (vecs[i].c1 >= 0) corrupt[vecs[i].c1] = 1'b1;
            run_a(vecs[i].name, vecs[i].eop_at, vecs[i].drop_sop, vecs[i].exp_err, vecs[i].exp_pass);
        end

        for (int r = 0; r < 4; r++) begin
            foreach (corrupt[k]) corrupt[k] = 1'b0;
            repeat ($urandom_range(0, 4)) corrupt[$urandom_range(0, NUM_A - 1)] = 1'b1;
            eop = ($urandom_range(0, 1) == 1) ? NUM_A - 1 : int'($urandom_range(0, NUM_A - 1));
            ds  = ($urandom_range(0, 3) == 0);
            e   = model_err(eop, ds);
            run_a($sformatf("rand%0d", r), eop, ds, e, e == 0);
        end

        // Controller never comes back after ERASE: the wait must time out.
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check("tmo_erase_valid", {a_valid, a_type}, {1'b1, OP_ERASE});
        @(negedge clk); ready_a = 1'b0;
        n = 1; saw_op = 0;
        while (!a_done && n < 3000) begin
            @(negedge clk); n++;
            if (a_valid) saw_op = 1;
        end
        check("tmo_latency", 64'(n >= 995 && n <= 1005), 64'd1);
        check("tmo_done", {a_done, a_tmo, a_pass, a_busy, a_err}, {1'b1, 1'b1, 1'b0, 1'b0, 9'd0});
        check("tmo_no_program", 64'(saw_op), 64'd0);
        ready_a = 1'b1;
        @(negedge clk);
        check("tmo_held", {a_done, a_tmo, a_pass}, {1'b0, 1'b1, 1'b0});

        // Second start during PROG_DATA is ignored; reset lands mid READ_DATA.
        wq.delete();
        foreach (corrupt[k]) corrupt[k] = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        serve_a(5, 1'b0, rec);
        while (!a_valid && n < 5000) begin @(negedge clk); n++; end
        @(negedge clk); ready_a = 1'b0;
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (NUM_A + 10) @(negedge clk);
        ready_a = 1'b1;
        check_write_stream("restart");
        serve_a(0, 1'b1, rec);
        check("restart_read_op", 64'(rec), {1'b1, 1'b1, OP_READ, 24'h000000, 9'd256});
        for (int k = 0; k < 50; k++) begin
            rvalid_a = 1'b1; rdata_a = wq[k].data; rsop_a = (k == 0); reop_a = 1'b0;
            @(negedge clk);
        end
        check("mid_read", {a_busy, a_err, a_done}, {1'b1, 9'd0, 1'b0});
        #2 rst_n = 1'b0;
        #1 check("mid_reset", {a_busy, a_done, a_pass, a_tmo, a_err, a_valid, a_type, a_addr, a_num,
                              a_wvalid, a_wdata, a_wsop, a_weop}, 64'd0);
        rvalid_a = 1'b0; rsop_a = 1'b0; ready_a = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_a("after_reset", NUM_A - 1, 1'b0, 0, 1'b1);

        // Single-byte instance with seed 0xA5.
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        wait_b_valid(ok);
        check("b_erase_op", {ok, b_type, b_addr, b_num}, {1'b1, OP_ERASE, 24'h000000, 9'd0});
        @(negedge clk); ready_b = 1'b0;
        repeat (3) @(negedge clk);
        ready_b = 1'b1;
        wait_b_valid(ok);
        check("b_prog_op", {ok, b_type, b_num}, {1'b1, OP_PROGRAM, 9'd1});
        @(negedge clk); ready_b = 1'b0;
        check("b_beat", {b_wvalid, b_wsop, b_weop, b_wdata}, {1'b1, 1'b1, 1'b1, 8'hA5});
        @(negedge clk);
        check("b_beat_end", {b_wvalid, b_wsop, b_weop}, 3'b000);
        repeat (2) @(negedge clk);
        ready_b = 1'b1;
        wait_b_valid(ok);
        check("b_read_op", {ok, b_type, b_num}, {1'b1, OP_READ, 9'd1});
        @(negedge clk); ready_b = 1'b0;
        rvalid_b = 1'b1; rdata_b = 8'hA5; rsop_b = 1'b1; reop_b = 1'b1;
        @(negedge clk);
        check("b_done", {b_done, b_pass, b_tmo, b_busy, b_err}, {1'b1, 1'b1, 1'b0, 1'b0, 9'd0});
        rvalid_b = 1'b0; rsop_b = 1'b0; reop_b = 1'b0; ready_b = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
